regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: three requesters (ALU, load, CSR) share one
// write port via round-robin; an optional post-reset sweep zeroes x1..x31.

// Per-lane grant: lane LANE wins when valid and no valid lane sits ahead of it
// in the rotation that starts at ptr_i.
module regfile_write_arbiter_lane #(
  parameter int NUM_LANES = 3,
  parameter int PW        = 2,
  parameter int LANE      = 0
) (
  input  logic [NUM_LANES-1:0] valid_i,
  input  logic [PW-1:0]        ptr_i,
  output logic                 grant_o
);
  localparam logic [PW-1:0] ME = PW'(LANE);

  logic [PW-1:0] j;
  logic          ahead;

  always_comb begin
    grant_o = valid_i[LANE];
    ahead   = 1'b1;
    j       = '0;
    for (int d = 0; d < NUM_LANES; d++) begin
      j = PW'((int'(ptr_i) + d) % NUM_LANES);
      if (j == ME)
        ahead = 1'b0;
      else if (ahead && valid_i[j])
        grant_o = 1'b0;
    end
  end
endmodule

module regfile_write_arbiter #(
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        init_busy
);
  localparam int NUM_LANES = 3;
  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int PW        = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [AW-1:0]   cnt_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;

  logic [NUM_LANES-1:0][AW-1:0] addr_v;
  logic [NUM_LANES-1:0][DW-1:0] data_v;
  logic [NUM_LANES-1:0]         grant_raw;
  logic [AW-1:0]                sel_addr;
  logic [DW-1:0]                sel_data;
  logic [PW-1:0]                ptr_d;
  logic                         accept;

  assign addr_v = req_addr;
  assign data_v = req_data;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    regfile_write_arbiter_lane #(
      .NUM_LANES(NUM_LANES),
      .PW       (PW),
      .LANE     (i)
    ) u_lane (
      .valid_i(req_valid),
      .ptr_i  (ptr_q),
      .grant_o(grant_raw[i])
    );
  end

  // Grants are suppressed during the clear sweep and while reset is held.
  assign req_ready = (state_q == RUN && !reset) ? grant_raw : '0;
  assign accept    = |req_ready;

  // req_ready is one-hot, so OR-ing the granted lanes is a plain mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    ptr_d    = ptr_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | addr_v[i];
        sel_data = sel_data | data_v[i];
        ptr_d    = PW'((i + 1) % NUM_LANES);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= INIT_CLEAR ? INIT : RUN;
      cnt_q   <= 5'd1;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        INIT: begin
          we_q   <= 1'b1;
          addr_q <= cnt_q;
          data_q <= '0;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            // x0 is hardwired: complete the handshake but drop the strobe.
            we_q   <= |sel_addr;
            addr_q <= sel_addr;
            data_q <= sel_data;
            ptr_q  <= ptr_d;
          end else begin
            we_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign rf_write_enable = we_q;
  assign rf_write_addr   = addr_q;
  assign rf_write_data   = data_q;
  assign init_busy       = (state_q == INIT);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: one instance with the clear sweep, one without, sharing stimulus.
module tb_regfile_write_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;

  logic [2:0]  a_ready, b_ready;
  logic        a_we, b_we, a_busy, b_busy;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.INIT_CLEAR(1'b1)) dut_a (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(a_ready), .rf_write_enable(a_we),
    .rf_write_addr(a_addr), .rf_write_data(a_data), .init_busy(a_busy));

  regfile_write_arbiter #(.INIT_CLEAR(1'b0)) dut_b (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(b_ready), .rf_write_enable(b_we),
    .rf_write_addr(b_addr), .rf_write_data(b_data), .init_busy(b_busy));

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  rdy;
    logic        we;
    logic        chk_ad;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] r, input logic we, input logic ca,
                              input logic [4:0] wa, input logic [31:0] wd);
    vec_t t;
    t.valid = v; t.addr = a; t.data = d; t.rdy = r;
    t.we = we; t.chk_ad = ca; t.waddr = wa; t.wdata = wd;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clear-sweep cycle on dut_a: the write of index k shows after the edge.
  task automatic init_cycle(input int k);
    @(posedge clock); #1;
    chk($sformatf("init_we_%0d", k), 96'(a_we), 96'd1);
    chk($sformatf("init_addr_%0d", k), 96'(a_addr), 96'(k));
    chk($sformatf("init_data_%0d", k), 96'(a_data), 96'd0);
    chk($sformatf("init_busy_%0d", k), 96'(a_busy), 96'(k < 31));
    if (k < 31) chk($sformatf("init_ready_%0d", k), 96'(a_ready), 96'd0);
  endtask

  localparam logic [14:0] A567 = {5'd7, 5'd6, 5'd5};
  localparam logic [95:0] DABC = {32'hC, 32'hB, 32'hA};

  initial begin
    tbl[0]  = mk(3'b111, A567, DABC, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA);
    tbl[1]  = mk(3'b111, A567, DABC, 3'b010, 1'b1, 1'b1, 5'd6, 32'hB);
    tbl[2]  = mk(3'b111, A567, DABC, 3'b100, 1'b1, 1'b1, 5'd7, 32'hC);
    tbl[3]  = mk(3'b111, A567, DABC, 3'b001, 1'b1, 1'b1, 5'd5, 32'hA);
    tbl[4]  = mk(3'b000, A567, DABC, 3'b000, 1'b0, 1'b1, 5'd5, 32'hA);
    tbl[5]  = mk(3'b010, 15'd0, {32'h0, 32'hFFFF_FFFF, 32'h0}, 3'b010, 1'b0, 1'b0, 5'd0, 32'h0);
    tbl[6]  = mk(3'b011, {5'd0, 5'd9, 5'd9}, {32'h0, 32'h2222_2222, 32'h1111_1111},
                 3'b001, 1'b1, 1'b1, 5'd9, 32'h1111_1111);
    tbl[7]  = mk(3'b011, {5'd0, 5'd9, 5'd9}, {32'h0, 32'h2222_2222, 32'h1111_1111},
                 3'b010, 1'b1, 1'b1, 5'd9, 32'h2222_2222);
    tbl[8]  = mk(3'b100, {5'd3, 5'd0, 5'd0}, {32'h3333_3333, 64'h0},
                 3'b100, 1'b1, 1'b1, 5'd3, 32'h3333_3333);
    tbl[9]  = mk(3'b110, {5'd4, 5'd12, 5'd0}, {32'h4444_4444, 32'hCCCC_CCCC, 32'h0},
                 3'b010, 1'b1, 1'b1, 5'd12, 32'hCCCC_CCCC);
    tbl[10] = mk(3'b110, {5'd4, 5'd12, 5'd0}, {32'h4444_4444, 32'hCCCC_CCCC, 32'h0},
                 3'b100, 1'b1, 1'b1, 5'd4, 32'h4444_4444);
    tbl[11] = mk(3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 1'b1, 5'd4, 32'h4444_4444);

    // Reset state, with all requesters valid to show grants are held off.
    reset = 1'b1; req_valid = 3'b111; req_addr = A567; req_data = DABC;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_a_we", 96'(a_we), 96'd0);
    chk("rst_a_addr", 96'(a_addr), 96'd0);
    chk("rst_a_data", 96'(a_data), 96'd0);
    chk("rst_a_busy", 96'(a_busy), 96'd1);
    chk("rst_a_ready", 96'(a_ready), 96'd0);
    chk("rst_b_ready", 96'(b_ready), 96'd0);
    chk("rst_b_we", 96'(b_we), 96'd0);
    chk("rst_b_busy", 96'(b_busy), 96'd0);

    // Release: dut_b grants CSR at once, dut_a starts the sweep.
    req_valid = 3'b100; req_addr = {5'd31, 10'd0}; req_data = {32'h1234_5678, 64'd0};
    reset = 1'b0;
    #1;
    chk("b_first_ready", 96'(b_ready), 96'b100);
    chk("a_busy_c0", 96'(a_busy), 96'd1);
    chk("a_ready_c0", 96'(a_ready), 96'd0);
    init_cycle(1);
    chk("b_first_we", 96'(b_we), 96'd1);
    chk("b_first_addr", 96'(b_addr), 96'd31);
    chk("b_first_data", 96'(b_data), 96'h1234_5678);
    req_valid = 3'b111; req_addr = A567; req_data = DABC;
    for (int k = 2; k <= 31; k++) init_cycle(k);

    // Round-robin table on dut_a (pointer starts at 0 after the sweep).
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid; req_addr = tbl[i].addr; req_data = tbl[i].data;
      #1;
      chk($sformatf("tbl%0d_ready", i), 96'(a_ready), 96'(tbl[i].rdy));
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_we", i), 96'(a_we), 96'(tbl[i].we));
      if (tbl[i].chk_ad) begin
        chk($sformatf("tbl%0d_addr", i), 96'(a_addr), 96'(tbl[i].waddr));
        chk($sformatf("tbl%0d_data", i), 96'(a_data), 96'(tbl[i].wdata));
      end
    end

    // Reset mid-RUN wipes a write that is on the port.
    req_valid = 3'b001; req_addr = {10'd0, 5'd17}; req_data = {64'd0, 32'h55};
    #1;
    chk("run_ready", 96'(a_ready), 96'b001);
    @(posedge clock); #1;
    chk("run_we", 96'(a_we), 96'd1);
    chk("run_addr", 96'(a_addr), 96'd17);
    reset = 1'b1;
    #1;
    chk("runrst_we", 96'(a_we), 96'd0);
    chk("runrst_addr", 96'(a_addr), 96'd0);
    chk("runrst_data", 96'(a_data), 96'd0);
    chk("runrst_busy", 96'(a_busy), 96'd1);
    chk("runrst_a_ready", 96'(a_ready), 96'd0);
    chk("runrst_b_ready", 96'(b_ready), 96'd0);

    // Reset in the middle of the sweep restarts it at x1.
    req_valid = 3'b111; req_addr = A567; req_data = DABC;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("sweep2_busy_c0", 96'(a_busy), 96'd1);
    for (int k = 1; k <= 10; k++) init_cycle(k);
    reset = 1'b1;
    #1;
    chk("initrst_we", 96'(a_we), 96'd0);
    chk("initrst_addr", 96'(a_addr), 96'd0);
    chk("initrst_busy", 96'(a_busy), 96'd1);
    chk("initrst_ready", 96'(a_ready), 96'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 1; k <= 31; k++) init_cycle(k);
    #1;
    chk("after_restart_ready", 96'(a_ready), 96'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
